fc_argmax_collect: RTL
======================

Name: fc_argmax_collect

Overview:
- Downstream stage of the fully-connected layer output stream.
- Consumes one output vector of M signed WIDTH-bit values per inference, beat by beat, over a valid/ready handshake.
- Tracks the running signed maximum and its index, then presents a single result (class index plus max value) over a second valid/ready handshake.
- Final classification stage of the generated accelerator; one instance per top-level network.

Parameters:
- WIDTH, 8, bit width of each signed input element and of output_max.
- M, 6, number of elements per vector; legal range 1..1024.
- LOGM, $clog2(M) (minimum 1), width of the index and element counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- input_valid  input  1  upstream element available.
- input_ready  output  1  block accepts an element this cycle.
- input_data  input  WIDTH  signed element, two's complement.
- output_valid  output  1  result available.
- output_ready  input  1  downstream accepts result.
- output_index  output  LOGM  position (0..M-1) of the maximum element in the vector.
- output_max  output  WIDTH  signed maximum value.

Behaviour:
- Handshakes:
  - Input transfer occurs on a rising edge with input_valid && input_ready.
  - Output transfer occurs on a rising edge with output_valid && output_ready.
  - input_ready and output_valid are decoded combinationally from state only, never from input_valid or output_ready. There are no combinational paths from inputs to outputs.
- States:
  - COLLECT:
    - input_ready=1, output_valid=0.
    - cnt counts accepted elements, 0..M-1.
  - RESULT:
    - input_ready=0, output_valid=1.
    - output_index and output_max stay stable until the transfer completes.
- Reset:
  - State=COLLECT, cnt=0, best_val=0, best_idx=0.
  - Outputs after reset: input_ready=1, output_valid=0, output_index=0, output_max=0.
  - Reset mid-operation discards any partial vector or pending result. The next accepted beat is element 0.
- On each input transfer in COLLECT:
  - If cnt==0: best_val<=input_data, best_idx<=0 unconditionally.
  - Otherwise, if input_data > best_val (signed compare): best_val<=input_data, best_idx<=cnt.
  - Ties keep the earlier index.
  - If cnt==M-1: cnt<=0 and state<=RESULT. Otherwise cnt<=cnt+1.
- In RESULT:
  - output_max=best_val, output_index=best_idx (registered values).
  - On output transfer, state<=COLLECT and input_ready=1 next cycle.
  - Stall of arbitrary length is allowed.
- Latency: output_valid rises on the first cycle after the edge that accepted element M-1.
- Throughput:
  - Element acceptance takes one cycle per element at best.
  - One bubble cycle per vector in RESULT, minimum.
- Input gaps: input_valid low in COLLECT holds all state; gaps of any length are allowed.
- M=1: every accepted element transitions directly to RESULT with output_index=0.
- Arithmetic: pure signed compare on WIDTH bits, no saturation needed.
  - -128 is a valid maximum when all elements equal -128.
- input_data is ignored while input_ready=0.

Optional Feature:
- Macro: ARGMAX_RELU_EN.
- Defined: each element is clamped to 0 before comparison (elements <=0 compare as 0), so output_max>=0 always.
  - Tie-break rules are unchanged; an all-negative vector yields output_index=0, output_max=0.
- Undefined: raw signed compare as described in Behaviour.

Test Plan:
- Basic, M=6: reset, then stream {3,-5,17,2,17,-1} back-to-back with output_ready=1 -> output_valid high one cycle after the 6th beat, output_index=2 (tie keeps first), output_max=17, input_ready=1 on the following cycle.
- All negative: stream {-128,-128,-7,-128,-9,-128} -> output_index=2, output_max=-7. With ARGMAX_RELU_EN -> output_index=0, output_max=0.
- Backpressure: after the vector {0,0,0,0,0,5}, hold output_ready=0 for 10 cycles with input_valid=1 -> input_ready=0 throughout, outputs stable at index 5 / max 5, no element consumed. Raise output_ready -> transfer, then the next vector starts at element 0.
- Input gaps: insert random input_valid=0 cycles between beats of {1,2,3,4,5,6} -> output_index=5, output_max=6, cnt unaffected by gaps.
- Reset mid-vector: accept 3 beats {100,0,0}, assert reset 1 cycle, then stream {1,2,3,4,5,0} -> output_index=4, output_max=5 (the 100 is discarded).
- Back-to-back vectors: two vectors {127,...} and {...,127 at index 5} with output_ready=1 constant -> results (0,127) then (5,127), exactly one bubble cycle between vectors.

Source files
------------

// File: rtl/fc_argmax_collect.sv
// fc_argmax_collect
//   Final classification stage. Consumes one vector of M signed WIDTH-bit
//   elements over a valid/ready stream, tracks the running signed maximum
//   and its position, then offers (index, max) over a second valid/ready
//   stream. Handshake outputs are decoded from state only.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high
//   input_valid   upstream element available
//   input_ready   element accepted this cycle (COLLECT)
//   input_data    signed element, two's complement
//   output_valid  result available (RESULT)
//   output_ready  downstream accepts result
//   output_index  position of the maximum element (0..M-1)
//   output_max    signed maximum value
//
// Build option
//   ARGMAX_RELU_EN : when defined, elements are clamped to 0 before the
//                    compare, so output_max is never negative.
//
// state   | meaning
// --------+--------------------------------------------------
// COLLECT | accepting elements, cnt = index of next element
// RESULT  | holding best index/value until downstream takes it

module fc_argmax_collect #(
  parameter int WIDTH = 8,
  parameter int M     = 6,
  parameter int LOGM  = (M > 1) ? $clog2(M) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             input_valid,
  output logic             input_ready,
  input  logic [WIDTH-1:0] input_data,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [LOGM-1:0]  output_index,
  output logic [WIDTH-1:0] output_max
);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_RESULT  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [LOGM-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] best_val_q, best_val_d;
  logic [LOGM-1:0]  best_idx_q, best_idx_d;

  logic [WIDTH-1:0] elem;
  logic             in_xfer;
  logic             out_xfer;
  logic             last_elem;

  assign in_xfer   = input_valid && (state_q == S_COLLECT);
  assign out_xfer  = output_ready && (state_q == S_RESULT);
  assign last_elem = (cnt_q == LOGM'(M - 1));

  always_comb begin
    elem = input_data;
`ifdef ARGMAX_RELU_EN
    // Non-positive elements compare as zero.
    if (input_data[WIDTH-1]) elem = '0;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_COLLECT;
      cnt_q      <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    case (state_q)
      S_COLLECT: begin
        if (in_xfer) begin
          // First element seeds the max unconditionally; afterwards a strict
          // greater-than keeps the earliest index on ties.
          if (cnt_q == '0) begin
            best_val_d = elem;
            best_idx_d = '0;
          end else if ($signed(elem) > $signed(best_val_q)) begin
            best_val_d = elem;
            best_idx_d = cnt_q;
          end
          if (last_elem) begin
            cnt_d   = '0;
            state_d = S_RESULT;
          end else begin
            cnt_d = cnt_q + LOGM'(1);
          end
        end
      end
      S_RESULT: begin
        if (out_xfer) state_d = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // Output decode, state only
  always_comb begin
    input_ready  = (state_q == S_COLLECT);
    output_valid = (state_q == S_RESULT);
    output_index = best_idx_q;
    output_max   = best_val_q;
  end

endmodule
